// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes,
// response error codes, FSM states and the request legality check.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ACCESS    = 2'b01,
        ST_WRITEBACK = 2'b10,
        ST_RESP      = 2'b11
    } lsu_state_e;

    // Misalignment / illegal size takes priority over out-of-range.
    function automatic logic [1:0] req_error(input logic [1:0]  size,
                                             input logic [31:0] addr,
                                             input logic [31:0] depth);
        logic misaligned;
        misaligned = (size == 2'b11) ||
                     ((size == SIZE_HALF) && addr[0]) ||
                     ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
        if (misaligned)
            return ERR_MISALIGN;
        else if ({2'b00, addr[31:2]} >= depth)
            return ERR_RANGE;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Big-endian lane extraction and merge. Byte lane 0 is [31:24], lane 3 is
// [7:0]; halfword offset 0 is [31:16], offset 2 is [15:0]. Store data is
// right-aligned in i_storeData.
module lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_storeData,
    output logic [31:0] o_loadValue,
    output logic [31:0] o_mergedWord
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword out of the memory word.
    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
    end

    // Extend the selected lane to 32 bits.
    always_comb begin
        o_loadValue = i_word;
        case (i_size)
            SIZE_BYTE: o_loadValue = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_loadValue = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:   o_loadValue = i_word;
        endcase
    end

    // Replace the target lane of the memory word with the store data.
    always_comb begin
        o_mergedWord = i_word;
        case (i_size)
            SIZE_BYTE: begin
                case (i_offset)
                    2'd0:    o_mergedWord[31:24] = i_storeData[7:0];
                    2'd1:    o_mergedWord[23:16] = i_storeData[7:0];
                    2'd2:    o_mergedWord[15:8]  = i_storeData[7:0];
                    default: o_mergedWord[7:0]   = i_storeData[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (i_offset[1])
                    o_mergedWord[15:0]  = i_storeData[15:0];
                else
                    o_mergedWord[31:16] = i_storeData[15:0];
            end
            default: o_mergedWord = i_storeData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. One request in flight; sub-word stores are a
// read (ACCESS) followed by a write of the merged word (WRITEBACK).
// Handshake: a request transfers on a rising edge where reqValid && reqReady;
// reqReady is high only in IDLE, respValid is a one-cycle pulse in RESP.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic [1:0]  respError,
    output logic [31:0] memAddress,
    output logic        memWriteEnable,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    output logic [1:0]  dbgState
);

    lsu_state_e  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [31:0] r_data;
    logic [31:0] r_merged;
    logic [31:0] r_respData;
    logic [1:0]  r_respError;
    logic [31:0] r_memAddress;

    logic        w_accept;
    logic [1:0]  w_reqError;
    logic [31:0] w_loadValue;
    logic [31:0] w_mergedWord;
    logic        w_writeEnable;
    logic [31:0] w_writeData;

    assign w_accept   = reqValid && reqReady;
    assign w_reqError = req_error(reqSize, reqAddress, 32'(DEPTH));

    lane_align u_lane_align (
        .i_word       (memReadData),
        .i_offset     (r_offset),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_storeData  (r_data),
        .o_loadValue  (w_loadValue),
        .o_mergedWord (w_mergedWord)
    );

    // Request FSM: capture at accept, access memory, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_size       <= SIZE_BYTE;
            r_unsigned   <= 1'b0;
            r_offset     <= 2'b00;
            r_data       <= 32'h0;
            r_merged     <= 32'h0;
            r_respData   <= 32'h0;
            r_respError  <= ERR_NONE;
            r_memAddress <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write    <= reqWrite;
                        r_size     <= reqSize;
                        r_unsigned <= reqUnsigned;
                        r_offset   <= reqAddress[1:0];
                        r_data     <= reqData;
                        if (w_reqError != ERR_NONE) begin
                            // Rejected requests never touch memAddress.
                            r_respData  <= 32'h0;
                            r_respError <= w_reqError;
                            r_state     <= ST_RESP;
                        end else begin
                            r_memAddress <= {2'b00, reqAddress[31:2]};
                            r_state      <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_respError <= ERR_NONE;
                    if (!r_write) begin
                        r_respData <= w_loadValue;
                        r_state    <= ST_RESP;
                    end else if (r_size == SIZE_WORD) begin
                        r_respData <= 32'h0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_merged   <= w_mergedWord;
                        r_respData <= 32'h0;
                        r_state    <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: r_state <= ST_RESP;
                ST_RESP:      r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    // Write strobe: word store in ACCESS or merged write in WRITEBACK, never under reset.
    always_comb begin
        w_writeEnable = 1'b0;
        w_writeData   = 32'h0;
        if (!rst) begin
            if ((r_state == ST_ACCESS) && r_write && (r_size == SIZE_WORD)) begin
                w_writeEnable = 1'b1;
                w_writeData   = r_data;
            end else if (r_state == ST_WRITEBACK) begin
                w_writeEnable = 1'b1;
                w_writeData   = r_merged;
            end
        end
    end

    assign reqReady       = (r_state == ST_IDLE);
    assign respValid      = (r_state == ST_RESP);
    assign respData       = r_respData;
    assign respError      = r_respError;
    assign memAddress     = r_memAddress;
    assign memWriteEnable = w_writeEnable;
    assign memWriteData   = w_writeData;
    assign dbgState       = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1024-word memory.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddress;
    logic [31:0] reqData;
    logic        respValid;
    logic [31:0] respData;
    logic [1:0]  respError;
    logic [31:0] memAddress;
    logic        memWriteEnable;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic [1:0]  dbgState;

    load_store_unit #(.DEPTH(1024)) dut (
        .clk            (clk),
        .rst            (rst),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqSize        (reqSize),
        .reqUnsigned    (reqUnsigned),
        .reqAddress     (reqAddress),
        .reqData        (reqData),
        .respValid      (respValid),
        .respData       (respData),
        .respError      (respError),
        .memAddress     (memAddress),
        .memWriteEnable (memWriteEnable),
        .memWriteData   (memWriteData),
        .memReadData    (memReadData),
        .dbgState       (dbgState)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    // behavioural memory with a backdoor preload port
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = 10'd0;
    logic [31:0] bd_data = 32'h0;
    assign memReadData = mem[memAddress[9:0]];
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (memWriteEnable) mem[memAddress[9:0]] <= memWriteData;
    end

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];
    int          cyc_q[$];
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    int          last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare every response against the head of the queue
    always @(negedge clk) begin
        logic [33:0] e;
        int ec;
        if (!rst && respValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual data=%h err=%h required=no response", respData, respError);
            end else begin
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                check("resp_data", respData, e[31:0]);
                check("resp_error", {30'b0, respError}, {30'b0, e[33:32]});
                check("resp_latency_cycle", 32'(cyc), 32'(ec));
            end
        end
        if (memWriteEnable) begin
            wr_count++;
            last_wr_addr = memAddress;
            last_wr_data = memWriteData;
        end
    end

    // driver tasks
    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = idx[9:0];
        bd_data = v;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] dat,
                         input logic [31:0] exp_data, input logic [1:0] exp_err, input int lat);
        int n;
        @(negedge clk);
        reqValid    = 1'b1;
        reqWrite    = wr;
        reqSize     = sz;
        reqUnsigned = uns;
        reqAddress  = addr;
        reqData     = dat;
        n = 0;
        while (!reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not ready required=ready within 20 cycles");
        end else begin
            exp_q.push_back({exp_err, exp_data});
            cyc_q.push_back(cyc + lat);
            last_acc = cyc + 1;
            @(posedge clk);
        end
    endtask

    // deassert valid and scramble fields to show they are not resampled
    task automatic idle();
        @(negedge clk);
        reqValid   = 1'b0;
        reqWrite   = 1'($urandom_range(0, 1));
        reqSize    = 2'($urandom_range(0, 3));
        reqAddress = $urandom;
        reqData    = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    int acc [0:4];
    logic [31:0] vals [0:4] = '{32'hA0A0A0A0, 32'h01234567, 32'hDEADBEEF, 32'h00000000, 32'hFFFF0001};
    int w0;

    initial begin
        rst = 1'b1;
        reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddress = 32'h0; reqData = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_respValid", {31'b0, respValid}, 32'd0);
        check("rst_respData", respData, 32'h0);
        check("rst_respError", {30'b0, respError}, 32'd0);
        check("rst_memAddress", memAddress, 32'h0);
        check("rst_memWriteEnable", {31'b0, memWriteEnable}, 32'd0);
        check("rst_memWriteData", memWriteData, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_reqReady", {31'b0, reqReady}, 32'd1);

        // word store then load back
        w0 = wr_count;
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 32'h0, 2'b00, 2);
        idle();
        drain();
        check("sw_write_count", 32'(wr_count - w0), 32'd1);
        check("sw_write_addr", last_wr_addr, 32'd32);
        check("sw_write_data", last_wr_data, 32'h12345678);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h12345678, 2'b00, 2);
        idle();
        drain();

        // byte store read-modify-write
        preload(32, 32'h11223344);
        w0 = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h81, 32'hCDEF12AB, 32'h0, 2'b00, 3);
        idle();
        drain();
        check("sb_write_count", 32'(wr_count - w0), 32'd1);
        check("sb_write_data", last_wr_data, 32'h11AB3344);
        check("sb_mem_word", mem[32], 32'h11AB3344);

        // sub-word loads with extension
        preload(32, 32'h80FF7F01);
        issue(1'b0, 2'b01, 1'b0, 32'h80, 32'h0, 32'hFFFF80FF, 2'b00, 2);
        issue(1'b0, 2'b01, 1'b1, 32'h80, 32'h0, 32'h000080FF, 2'b00, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h83, 32'h0, 32'h00000001, 2'b00, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, 32'hFFFFFF80, 2'b00, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h82, 32'h0, 32'h00007F01, 2'b00, 2);
        issue(1'b0, 2'b00, 1'b1, 32'h81, 32'h0, 32'h000000FF, 2'b00, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h81, 32'h0, 32'hFFFFFFFF, 2'b00, 2);
        idle();
        drain();

        // halfword store at offset 2, then store-then-load
        issue(1'b1, 2'b01, 1'b0, 32'h82, 32'h1234BEEF, 32'h0, 2'b00, 3);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h80FFBEEF, 2'b00, 2);
        idle();
        drain();
        check("sh_mem_word", mem[32], 32'h80FFBEEF);

        // rejected requests
        w0 = wr_count;
        issue(1'b0, 2'b10, 1'b0, 32'h82,   32'h0, 32'h0, 2'b01, 1);
        issue(1'b1, 2'b01, 1'b0, 32'h81,   32'h5555, 32'h0, 2'b01, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 2'b10, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h80,   32'h0, 32'h0, 2'b01, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 32'h0, 2'b01, 1);
        issue(1'b1, 2'b10, 1'b0, 32'h2000, 32'h77777777, 32'h0, 2'b10, 1);
        idle();
        drain();
        check("err_no_writes", 32'(wr_count - w0), 32'd0);
        check("err_mem_untouched", mem[32], 32'h80FFBEEF);

        // reset during WRITEBACK of a byte store
        preload(33, 32'hCAFEF00D);
        w0 = wr_count;
        @(negedge clk);
        check("rst_test_ready", {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddress = 32'h85; reqData = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        check("rst_test_in_writeback", {30'b0, dbgState}, 32'd2);
        rst = 1'b1;
        #1;
        check("rst_forces_we_low", {31'b0, memWriteEnable}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_test_ready_after", {31'b0, reqReady}, 32'd1);
        repeat (4) @(negedge clk);
        check("rst_test_no_write", 32'(wr_count - w0), 32'd0);
        check("rst_test_mem_word", mem[33], 32'hCAFEF00D);

        // five queued loads with valid held high
        for (int i = 0; i < 5; i++) preload(40 + i, vals[i]);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 2'b10, 1'b0, 32'((40 + i) * 4), $urandom, vals[i], 2'b00, 2);
            acc[i] = last_acc;
        end
        idle();
        drain();
        for (int i = 1; i < 5; i++) check("queued_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
